redun_work_num_gen: RTL and testbench
=====================================

// Module: redun_work_num_gen
// PURPOSE
//  Parametrised successor to the per-phase redundancy counter. For each of NUM_CH phases:
//   - counts the set bits (bypassed modules) in that phase's redundancy bitmap;
//   - derives the working link count per phase;
//   - raises a settled-sync pulse once all bitmaps have been stable for SETTLE_CYC clocks.
//  Sits between the host redundancy registers and the carrier/modulation ring.
// PARAMETERS
//  NUM_CH      3       number of phases/channels (1..8)
//  NUM_MODEL   18      modules per phase = bitmap bits scanned (1..24)
//  SETTLE_CYC  250     stable clocks after last bitmap change before o_redun_Syn (>=1)
//  MODE_INDEP  16'h55AA  i_VCU_Mode value selecting independent-phase mode
// PORTS
//  i_clk_20M       in   1          20 MHz system clock
//  i_reset_n       in   1          synchronous, active-low reset
//  i_LinkNum_Total in   16         total links per phase
//  i_VCU_Mode      in   16         mode word; ==MODE_INDEP -> independent, else common
//  i_redun_word    in   NUM_CH*24  bitmap per channel; ch c = [24c+23:24c]; bits >= NUM_MODEL ignored
//  o_redun_num     out  NUM_CH*6   bypassed-module count per channel, registered
//  o_LinkNum_Work  out  NUM_CH*16  working links per channel, registered
//  o_underflow     out  NUM_CH     subtrahend exceeded i_LinkNum_Total (output clamped to 0)
//  o_valid         out  1          all counts reflect current bitmaps
//  o_redun_Syn     out  1          one-clock pulse once bitmaps have settled
// BEHAVIOUR
//  Reset: all outputs, counters, and registered words = 0; FSM = IDLE.
//  Per channel c:
//   - word_reg[c] <= i_redun_word[c] & mask(NUM_MODEL), every clock; word_d[c] <= word_reg[c].
//   - Change when word_reg != word_d: scan restarts (cnt=0, tmp=0); o_redun_num holds its old value.
//   - word_reg == 0 (takes priority over change): num=0, cnt=0, tmp=0 on the same edge.
//   - Otherwise, serial scan one bit per clock:
//       cnt < NUM_MODEL:  tmp += word_reg[cnt]; cnt++.
//       cnt == NUM_MODEL: num <= tmp; tmp <= 0; cnt <= 0; done[c] <= 1.
//  Latency (E0 = edge that samples the new i_redun_word):
//   - E1: change detected; done[c] <= 0.
//   - E2..E(NUM_MODEL+1): bits accumulated.
//   - E(NUM_MODEL+2): num loaded.
//   - E(NUM_MODEL+3): o_LinkNum_Work updated.
//   - Zero-word path: num = 0 at E1; work updated at E2.
//  Work computation (registered; arithmetic width 17 bits, unsigned):
//   - independent mode: sub[c] = num[c].
//   - common mode: sub[c] = sum of num over all channels; sum width = clog2(NUM_CH*NUM_MODEL+1).
//   - If sub[c] > total: o_LinkNum_Work[c] = 0 and o_underflow[c] = 1.
//     Else: o_LinkNum_Work[c] = total - sub[c] and o_underflow[c] = 0.
//   - A mode change takes effect on the next edge (no rescan).
//  o_valid = AND of done[c] over all channels, registered.
//   - Zero-word channel counts as done.
//   - Drops the clock after any change is detected.
//  Settle FSM (global):
//   - IDLE: any change -> WAIT with scnt = 0.
//   - WAIT: scnt++ each clock; any further change resets scnt to 0 (stays in WAIT).
//       scnt == SETTLE_CYC-1 and no change -> SYNC.
//   - SYNC: o_redun_Syn = 1 for exactly one clock -> IDLE.
//   - Change arriving in SYNC: pulse is still emitted, then FSM goes to WAIT with scnt = 0.
//  Reset mid-scan or mid-WAIT: everything cleared at once; no pulse is emitted.
//  After reset, the first nonzero word is treated as a change (word_d = 0).
// TESTING
//  1 Defaults, ch0 = 0x00000F, ch1 = ch2 = 0, total = 20, mode = 0x55AA:
//      at E21 work = {20,20,16}; o_redun_num ch0 = 4; o_valid high at E21.
//  2 Same bitmaps, mode = 0x0000:
//      all work = 16 on the next edge; mode back to 0x55AA restores {20,20,16}.
//  3 ch0..2 = 0xFFFFFF (18 bits counted), total = 40, common mode:
//      sum = 54 > 40 -> all work = 0, o_underflow = 3'b111.
//  4 ch1 changes every 100 clocks for 5 changes, then stable:
//      exactly one o_redun_Syn, 250 clocks after the last detected change.
//  5 ch0 changes at scan cnt = 9:
//      scan restarts; old num held until the new count loads 20 clocks later.
//      No intermediate value appears.
//  6 Assert reset during WAIT and mid-scan:
//      outputs = 0 on the next edge; no Syn pulse; after release, scenario 1 timing repeats.

Source files
------------

// File: rtl/redun_work_num_gen.sv
// Per-phase redundancy bitmap counter and working-link calculator.
// Serially counts bypassed modules per phase and raises a settle pulse.
module redun_work_num_gen #(
    parameter int          NUM_CH     = 3,
    parameter int          NUM_MODEL  = 18,
    parameter int          SETTLE_CYC = 250,
    parameter logic [15:0] MODE_INDEP = 16'h55AA
) (
    input  logic                   i_clk_20M,
    input  logic                   i_reset_n,
    input  logic [15:0]            i_LinkNum_Total,
    input  logic [15:0]            i_VCU_Mode,
    input  logic [NUM_CH*24-1:0]   i_redun_word,
    output logic [NUM_CH*6-1:0]    o_redun_num,
    output logic [NUM_CH*16-1:0]   o_LinkNum_Work,
    output logic [NUM_CH-1:0]      o_underflow,
    output logic                   o_valid,
    output logic                   o_redun_Syn
);

    localparam int SUMW = $clog2(NUM_CH * NUM_MODEL + 1);
    localparam int SCW  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [SCW-1:0] SC_LAST = SCW'(SETTLE_CYC - 1);
    localparam logic [4:0]     CNT_END = 5'(NUM_MODEL);
    localparam logic [23:0]    MASK    = 24'((25'd1 << NUM_MODEL) - 25'd1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SYNC
    } state_t;

    logic [23:0]     r_word_reg [NUM_CH];
    logic [23:0]     r_word_d   [NUM_CH];
    logic [4:0]      r_cnt      [NUM_CH];
    logic [5:0]      r_tmp      [NUM_CH];
    logic [5:0]      r_num      [NUM_CH];
    logic [15:0]     r_work     [NUM_CH];
    logic [NUM_CH-1:0] r_done;
    logic [NUM_CH-1:0] r_unf;
    logic            r_valid;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [SCW-1:0]  r_scnt;
    logic [SCW-1:0]  w_scnt_nxt;
    logic            w_syn;

    logic [NUM_CH-1:0] w_change;
    logic            w_any_change;
    logic [SUMW-1:0] w_sum;
    logic [16:0]     w_sub      [NUM_CH];
    logic [16:0]     w_total;
    logic            w_indep;

    // Change detect: registered word differs from its delayed copy
    always_comb begin
        w_change = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_change[c] = (r_word_reg[c] != r_word_d[c]);
        end
        w_any_change = |w_change;
    end

    // Capture masked bitmaps and keep a one-clock-delayed copy
    always_ff @(posedge i_clk_20M) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (!i_reset_n) begin
                r_word_reg[c] <= '0;
                r_word_d[c]   <= '0;
            end else begin
                r_word_reg[c] <= i_redun_word[24*c +: 24] & MASK;
                r_word_d[c]   <= r_word_reg[c];
            end
        end
    end

    // Serial popcount, one bit per clock; zero word short-circuits
    always_ff @(posedge i_clk_20M) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (!i_reset_n) begin
                r_cnt[c]  <= '0;
                r_tmp[c]  <= '0;
                r_num[c]  <= '0;
                r_done[c] <= 1'b0;
            end else if (r_word_reg[c] == '0) begin
                r_cnt[c]  <= '0;
                r_tmp[c]  <= '0;
                r_num[c]  <= '0;
                r_done[c] <= 1'b1;
            end else if (w_change[c]) begin
                r_cnt[c]  <= '0;
                r_tmp[c]  <= '0;
                r_done[c] <= 1'b0;
            end else if (r_cnt[c] == CNT_END) begin
                r_num[c]  <= r_tmp[c];
                r_tmp[c]  <= '0;
                r_cnt[c]  <= '0;
                r_done[c] <= 1'b1;
            end else begin
                r_tmp[c] <= r_tmp[c] + 6'(r_word_reg[c][r_cnt[c]]);
                r_cnt[c] <= r_cnt[c] + 5'd1;
            end
        end
    end

    // Subtrahend per channel: own count or sum of all counts
    always_comb begin
        w_indep = (i_VCU_Mode == MODE_INDEP);
        w_total = {1'b0, i_LinkNum_Total};
        w_sum   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_sum = w_sum + SUMW'(r_num[c]);
        end
        for (int c = 0; c < NUM_CH; c++) begin
            w_sub[c] = w_indep ? 17'(r_num[c]) : 17'(w_sum);
        end
    end

    // Working links, clamped at zero with underflow flag
    always_ff @(posedge i_clk_20M) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (!i_reset_n) begin
                r_work[c] <= '0;
                r_unf[c]  <= 1'b0;
            end else if (w_sub[c] > w_total) begin
                r_work[c] <= '0;
                r_unf[c]  <= 1'b1;
            end else begin
                r_work[c] <= 16'(w_total - w_sub[c]);
                r_unf[c]  <= 1'b0;
            end
        end
    end

    // All channels finished counting their current bitmaps
    always_ff @(posedge i_clk_20M) begin
        if (!i_reset_n) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= &r_done;
        end
    end

    // Settle FSM state and counter registers
    always_ff @(posedge i_clk_20M) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
            r_scnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_scnt  <= w_scnt_nxt;
        end
    end

    // Settle FSM next state; any change restarts the settle window
    always_comb begin
        w_state_nxt = r_state;
        w_scnt_nxt  = r_scnt;
        w_syn       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_any_change) begin
                    w_state_nxt = S_WAIT;
                    w_scnt_nxt  = '0;
                end
            end
            S_WAIT: begin
                if (w_any_change) begin
                    w_scnt_nxt = '0;
                end else if (r_scnt == SC_LAST) begin
                    w_state_nxt = S_SYNC;
                    w_scnt_nxt  = '0;
                end else begin
                    w_scnt_nxt = r_scnt + 1'b1;
                end
            end
            S_SYNC: begin
                w_syn      = 1'b1;
                w_scnt_nxt = '0;
                if (w_any_change) begin
                    w_state_nxt = S_WAIT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_scnt_nxt  = '0;
            end
        endcase
    end

    // Flatten per-channel registers onto output buses
    always_comb begin
        o_redun_num    = '0;
        o_LinkNum_Work = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            o_redun_num[6*c +: 6]     = r_num[c];
            o_LinkNum_Work[16*c +: 16] = r_work[c];
        end
    end

    assign o_underflow = r_unf;
    assign o_valid     = r_valid;
    assign o_redun_Syn = w_syn;

endmodule

// File: tb/tb_redun_work_num_gen.sv
// Directed bench for redun_work_num_gen.
// Linear scenario sequence with hand-computed expectations.
module tb_redun_work_num_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] total;
    logic [15:0] mode;
    logic [71:0] word;
    logic [17:0] num;
    logic [47:0] work;
    logic [2:0]  unf;
    logic        valid;
    logic        syn;

    int n_checks = 0;
    int n_err    = 0;
    int syn_cnt  = 0;
    int syn_base = 0;
    int bad      = 0;

    localparam logic [47:0] W20X3   = 48'h0014_0014_0014;
    localparam logic [47:0] W201616 = 48'h0014_0014_0010;
    localparam logic [47:0] W16X3   = 48'h0010_0010_0010;
    localparam logic [47:0] W36X3   = 48'h0024_0024_0024;
    localparam logic [47:0] W1X3    = 48'h0001_0001_0001;
    localparam logic [17:0] N18X3   = 18'h12492;

    always #25 clk = ~clk;

    redun_work_num_gen dut (
        .i_clk_20M       (clk),
        .i_reset_n       (rst_n),
        .i_LinkNum_Total (total),
        .i_VCU_Mode      (mode),
        .i_redun_word    (word),
        .o_redun_num     (num),
        .o_LinkNum_Work  (work),
        .o_underflow     (unf),
        .o_valid         (valid),
        .o_redun_Syn     (syn)
    );

    always @(negedge clk) begin
        if (syn === 1'b1) syn_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        total = 16'd20;
        mode  = 16'h55AA;
        word  = '0;
        step(3);
        chk("rst_work", work, 0);
        chk("rst_num", num, 0);
        chk("rst_unf", unf, 0);
        chk("rst_valid", valid, 0);
        chk("rst_syn", syn, 0);
        rst_n = 1'b1;
        step(5);
        chk("idle_work", work, W20X3);
        chk("idle_valid", valid, 1);

        // Scenario 1: ch0 = 0x0F, independent mode
        word = {24'h0, 24'h0, 24'h00000F};
        step(3);
        chk("s1_valid_drop", valid, 0);
        step(17);
        chk("s1_num_e19", num[5:0], 0);
        step(1);
        chk("s1_num_e20", num[5:0], 4);
        chk("s1_work_e20", work, W20X3);
        chk("s1_valid_e20", valid, 0);
        step(1);
        chk("s1_work_e21", work, W201616);
        chk("s1_valid_e21", valid, 1);
        chk("s1_unf", unf, 0);
        step(229);
        chk("s1_syn_e250", syn, 0);
        step(1);
        chk("s1_syn_e251", syn, 1);
        step(1);
        chk("s1_syn_e252", syn, 0);

        // Scenario 2: common mode and back
        mode = 16'h0000;
        step(1);
        chk("s2_common", work, W16X3);
        mode = 16'h55AA;
        step(1);
        chk("s2_indep", work, W201616);

        // Scenario 3: all 18 bits set, common mode underflow
        word  = {24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF};
        total = 16'd40;
        mode  = 16'h0000;
        step(21);
        chk("s3_work_e20", work, W36X3);
        chk("s3_unf_e20", unf, 0);
        step(1);
        chk("s3_num", num, N18X3);
        chk("s3_work", work, 0);
        chk("s3_unf", unf, 3'b111);
        total = 16'd54;
        step(1);
        chk("s3_eq_work", work, 0);
        chk("s3_eq_unf", unf, 0);
        total = 16'd53;
        step(1);
        chk("s3_lt_unf", unf, 3'b111);
        total = 16'd55;
        step(1);
        chk("s3_gt_work", work, W1X3);
        chk("s3_gt_unf", unf, 0);

        // Scenario 4: ch1 changes five times, 100 clocks apart
        syn_base = syn_cnt;
        for (int i = 0; i < 5; i++) begin
            word = {24'hFFFFFF, 24'((1 << (i + 1)) - 1), 24'hFFFFFF};
            if (i < 4) step(100);
        end
        step(251);
        chk("s4_syn_early", syn, 0);
        chk("s4_no_pulse", syn_cnt - syn_base, 0);
        step(1);
        chk("s4_syn", syn, 1);
        step(100);
        chk("s4_one_pulse", syn_cnt - syn_base, 1);

        // Scenario 5: ch0 changes again at scan cnt = 9
        word = {24'hFFFFFF, 24'h00001F, 24'h0000FF};
        step(10);
        word = {24'hFFFFFF, 24'h00001F, 24'h00003F};
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (num[5:0] !== 6'd18) bad++;
        end
        chk("s5_hold", bad, 0);
        chk("s5_valid_mid", valid, 0);
        step(1);
        chk("s5_num_new", num[5:0], 6);
        step(1);
        chk("s5_valid", valid, 1);

        // Scenario 6a: reset during WAIT, bitmaps zero afterwards
        total    = 16'd20;
        mode     = 16'h55AA;
        syn_base = syn_cnt;
        word     = {24'h0, 24'h0, 24'h00000F};
        step(10);
        rst_n = 1'b0;
        word  = '0;
        step(1);
        chk("s6a_work", work, 0);
        chk("s6a_num", num, 0);
        chk("s6a_valid", valid, 0);
        step(3);
        rst_n = 1'b1;
        step(300);
        chk("s6a_no_syn", syn_cnt - syn_base, 0);
        chk("s6a_work_idle", work, W20X3);

        // Scenario 6b: reset mid-scan, then scenario 1 timing
        word = {24'h0, 24'h0, 24'h00000F};
        step(10);
        rst_n = 1'b0;
        step(1);
        chk("s6b_work", work, 0);
        chk("s6b_num", num, 0);
        chk("s6b_unf", unf, 0);
        step(2);
        syn_base = syn_cnt;
        rst_n = 1'b1;
        step(21);
        chk("s6b_work_e20", work, W20X3);
        chk("s6b_num_e20", num[5:0], 4);
        step(1);
        chk("s6b_work_e21", work, W201616);
        chk("s6b_valid_e21", valid, 1);
        step(229);
        chk("s6b_syn_e250", syn_cnt - syn_base, 0);
        step(1);
        chk("s6b_syn_e251", syn, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
